// File: rtl/core_pkg.sv
// Shared core definitions: uop width, last-flag position and uop field layout.
// Field positions are informational; the sequencer treats uops as opaque.
package core_pkg;

  localparam int UOP_W        = 20;
  localparam int UOP_LAST_BIT = UOP_W;

  // Field bit positions within a uop, used only for decoding in benches.
  localparam int UOP_ALU_FN_HI   = 19;
  localparam int UOP_ALU_FN_LO   = 16;
  localparam int UOP_USE_CARRY   = 15;
  localparam int UOP_LD          = 14;
  localparam int UOP_WR          = 13;
  localparam int UOP_WR_FLAGS    = 12;
  localparam int UOP_DEST_HI     = 11;
  localparam int UOP_DEST_LO     = 8;
  localparam int UOP_WB_ADDR     = 7;
  localparam int UOP_SEL_K       = 6;
  localparam int UOP_B_HI        = 5;
  localparam int UOP_B_LO        = 3;
  localparam int UOP_A_HI        = 2;
  localparam int UOP_A_LO        = 0;

  // Number of entries a bundle occupies (1..3); a count of 3 saturates to 3 entries.
  function automatic logic [1:0] push_len(input logic [1:0] uop_count);
    logic [1:0] n;
    case (uop_count)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd3;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uop_ram.sv
// Uop storage: up to three consecutive writes per cycle starting at base,
// indices wrap naturally at DEPTH; one asynchronous read port.
module uop_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 21,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] base,
  input  logic [1:0]    n,
  input  logic [W-1:0]  wdata_0,
  input  logic [W-1:0]  wdata_1,
  input  logic [W-1:0]  wdata_2,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[base] <= wdata_0;
    if (we && n >= 2'd2) mem[base + AW'(1)] <= wdata_1;
    if (we && n == 2'd3) mem[base + AW'(2)] <= wdata_2;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uop_sequencer.sv
// Micro-op issue queue: accepts whole decoder bundles, issues one uop per cycle
// in execution order and tags the final uop of each instruction.
module uop_sequencer
  import core_pkg::push_len;
#(
  parameter int DEPTH = 8,
  parameter int UOP_W = core_pkg::UOP_W
) (
  input  logic                     clk,
  input  logic                     a_rst,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     feed_req,
  input  logic                     feed_ack,
  input  logic [UOP_W-1:0]         uop_0,
  input  logic [UOP_W-1:0]         uop_1,
  input  logic [UOP_W-1:0]         uop_2,
  input  logic [1:0]               uop_count,
  input  logic                     exec_ready,
  output logic [UOP_W-1:0]         uop,
  output logic                     uop_valid,
  output logic                     uop_last,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH - 3);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    push_n;
  logic          push, pop;
  logic [UOP_W:0] ent_0, ent_1, ent_2, head;

  assign push_n    = push_len(uop_count);
  assign feed_req  = ~hold & (count <= FILL_MAX);
  assign push      = feed_ack & feed_req & ~flush;
  assign uop_valid = (count != '0);
  assign pop       = uop_valid & exec_ready & ~hold;

  // Entries in execution order; the last flag rides on uop_0 only.
  always_comb begin
    ent_0 = {1'b1, uop_0};
    ent_1 = '0;
    ent_2 = '0;
    case (push_n)
      2'd2: begin
        ent_0 = {1'b0, uop_1};
        ent_1 = {1'b1, uop_0};
      end
      2'd3: begin
        ent_0 = {1'b0, uop_2};
        ent_1 = {1'b0, uop_1};
        ent_2 = {1'b1, uop_0};
      end
      default: ;
    endcase
  end

  uop_ram #(.DEPTH(DEPTH), .W(UOP_W + 1)) u_ram (
    .clk     (clk),
    .we      (push),
    .base    (wr_ptr),
    .n       (push_n),
    .wdata_0 (ent_0),
    .wdata_1 (ent_1),
    .wdata_2 (ent_2),
    .raddr   (rd_ptr),
    .rdata   (head)
  );

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(push_n);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (push ? CW'(push_n) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

  assign uop      = uop_valid ? head[UOP_W-1:0] : '0;
  assign uop_last = uop_valid & head[UOP_W];
  assign level    = count;

endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboard bench for uop_sequencer: a queue of expected {last, uop} entries
// is filled by the stimulus and drained by an independent negedge monitor.
module tb_uop_sequencer;

  localparam int DEPTH = 8;
  localparam int UW    = 20;

  logic          clk = 1'b0;
  logic          a_rst = 1'b0;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic          feed_req;
  logic          feed_ack = 1'b0;
  logic [UW-1:0] uop_0 = '0, uop_1 = '0, uop_2 = '0;
  logic [1:0]    uop_count = '0;
  logic          exec_ready = 1'b0;
  logic [UW-1:0] uop;
  logic          uop_valid;
  logic          uop_last;
  logic [3:0]    level;

  int compared = 0;
  int mismatched = 0;
  logic [UW:0] q[$];

  uop_sequencer #(.DEPTH(DEPTH), .UOP_W(UW)) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .hold       (hold),
    .flush      (flush),
    .feed_req   (feed_req),
    .feed_ack   (feed_ack),
    .uop_0      (uop_0),
    .uop_1      (uop_1),
    .uop_2      (uop_2),
    .uop_count  (uop_count),
    .exec_ready (exec_ready),
    .uop        (uop),
    .uop_valid  (uop_valid),
    .uop_last   (uop_last),
    .level      (level)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares the visible head/level against the reference queue,
  // then retires the head when the consumer takes it.
  always @(negedge clk) begin
    if (a_rst) begin
      chk("level", 32'(level), 32'(q.size()));
      chk("feed_req", 32'(feed_req), 32'(!hold && (q.size() <= DEPTH - 3)));
      chk("uop_valid", 32'(uop_valid), 32'(q.size() != 0));
      if (q.size() == 0) begin
        chk("uop_empty", 32'(uop), 32'd0);
        chk("last_empty", 32'(uop_last), 32'd0);
      end else begin
        chk("uop", 32'(uop), 32'(q[0][UW-1:0]));
        chk("uop_last", 32'(uop_last), 32'(q[0][UW]));
        if (exec_ready && !hold) void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic ack, input logic [1:0] cnt, input logic [UW-1:0] u0,
                      input logic [UW-1:0] u1, input logic [UW-1:0] u2,
                      input logic er, input logic hd, input logic fl);
    bit will_push;
    int n;
    feed_ack = ack; uop_count = cnt; uop_0 = u0; uop_1 = u1; uop_2 = u2;
    exec_ready = er; hold = hd; flush = fl;
    will_push = ack && !hd && !fl && (q.size() <= DEPTH - 3);
    n = (cnt == 2'd0) ? 1 : (cnt == 2'd1) ? 2 : 3;
    @(posedge clk);
    if (fl) q.delete();
    else if (will_push) begin
      if (n == 3) q.push_back({1'b0, u2});
      if (n >= 2) q.push_back({1'b0, u1});
      q.push_back({1'b1, u0});
    end
    #1;
  endtask

  task automatic idle(input logic er, input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, 2'd0, '0, '0, '0, er, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 100) begin
      idle(1'b1, 1);
      guard++;
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d entries left expected 0", q.size());
    end
  endtask

  initial begin
    int i, guard;
    bit pushed;
    logic [UW-1:0] r0, r1, r2;

    repeat (3) @(posedge clk);
    #3 a_rst = 1'b1;
    @(posedge clk); #1;
    idle(1'b0, 2);

    // Bundle order: A, B, C issued on consecutive cycles, last only on C.
    step(1'b1, 2'd2, 20'h0000C, 20'h0000B, 20'h0000A, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 4);

    // Back-pressure to level 6, then feed_ack ignored while feed_req is low.
    step(1'b1, 2'd2, 20'h00103, 20'h00102, 20'h00101, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 20'h00106, 20'h00105, 20'h00104, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 2'd0, 20'h00FFF, '0, '0, 1'b0, 1'b0, 1'b0);

    // Pop down to 4, then simultaneous push of two and pop of one.
    idle(1'b1, 2);
    step(1'b1, 2'd1, 20'h00202, 20'h00201, '0, 1'b1, 1'b0, 1'b0);

    // Flush with a same-cycle bundle offered.
    step(1'b1, 2'd2, 20'h00303, 20'h00302, 20'h00301, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Hold at level 3 with exec_ready high.
    step(1'b1, 2'd2, 20'h00403, 20'h00402, 20'h00401, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 2'd0, 20'h00EEE, '0, '0, 1'b1, 1'b1, 1'b0);

    // Twenty single-uop bundles under random exec_ready, crossing the wrap.
    i = 1; guard = 0;
    while (i <= 20 && guard < 500) begin
      pushed = (q.size() <= DEPTH - 3);
      step(1'b1, 2'd0, UW'(i), '0, '0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (pushed) i++;
      guard++;
    end
    compared++;
    if (i <= 20) begin
      mismatched++;
      $display("FAIL wrap_push_timeout: pushed %0d expected 20", i - 1);
    end
    drain();

    // Randomised traffic including uop_count=3, hold and flush.
    for (int k = 0; k < 400; k++) begin
      r0 = UW'($urandom); r1 = UW'($urandom); r2 = UW'($urandom);
      step(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), r0, r1, r2,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 29) == 0));
    end
    drain();

    // Asynchronous reset in the middle of an instruction.
    step(1'b1, 2'd2, 20'h00503, 20'h00502, 20'h00501, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1);
    a_rst = 1'b0;
    q.delete();
    @(negedge clk);
    #2 a_rst = 1'b1;
    @(posedge clk); #1;
    idle(1'b1, 3);
    step(1'b1, 2'd1, 20'h00602, 20'h00601, '0, 1'b1, 1'b0, 1'b0);
    drain();
    idle(1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
